// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the decoupled RV32I fetch stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fetch_queue_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  // One buffered fetch result as presented to decode.
  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] instr;
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] pc_plus4;
    logic                    pred;
  } fetch_entry_t;

  // Sign-extended J-type immediate; takes only the instruction bits it needs.
  function automatic logic [DEFAULT_XLEN-1:0] j_imm(input logic [31:12] instr);
    return {{(DEFAULT_XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with synchronous flush and occupancy count.
// Latency: pushed word readable at the head on the cycle after the push.
// Backpressure: push ignored when full (unless popping), pop ignored when empty.
//
// Ports: clk, reset_n (async active-low), flush, push/push_dat, pop/pop_dat,
//        full, empty, count (0..DEPTH). DEPTH must be a power of 2.
module fetch_queue_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch stage: owns the PC, keeps up to DEPTH requests/words in flight or queued.
// Latency: a returned word is visible to decode the cycle after imem_rvalid (no bypass).
// Backpressure: decode_ready low holds the head; issue stops when queued+in-flight hits DEPTH.
//
// Ports: clk, reset_n (async active-low);
//        imem_req/imem_addr/imem_ready  - in-order request channel (req&ready = issue)
//        imem_rvalid/imem_rdata         - in-order responses, latency >= 1
//        redirect/redirect_pc           - execute-stage control transfer, highest priority
//        instr_valid/decode_ready       - head handshake to decode
//        instrD/pcD/pc_plus4D/pred_taken - head entry contents (0 when empty)
// Optional feature: define FETCH_JAL_PREDICT_EN to redirect fetch on JAL at push time.
// XLEN must equal fetch_queue_pkg::DEFAULT_XLEN, the width the queue entry is laid out for.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            decode_ready,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic            pred_taken
);

  localparam int             CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_OCC = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight;   // issued, response not yet seen (includes ones to drop)
  logic [CW-1:0]   drop;       // oldest outstanding responses that belong to a dead path

  logic [CW-1:0]   q_count;
  logic [CW-1:0]   p_count;
  logic            q_full, q_empty, p_full, p_empty;
  logic [CW:0]     occupancy;
  logic [XLEN-1:0] pend_pc;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            discard, push_vld, pop_vld, issue, jal_take;
  logic            unused_fifo_status;

  assign occupancy = {1'b0, q_count} + {1'b0, inflight};
  assign discard   = redirect || (drop != '0);
  assign push_vld  = imem_rvalid && !discard;

`ifdef FETCH_JAL_PREDICT_EN
  logic [XLEN-1:0] jal_target;
  assign jal_take   = push_vld && (imem_rdata[6:0] == OPC_JAL);
  assign jal_target = pend_pc + j_imm(imem_rdata[31:12]);
`else
  assign jal_take   = 1'b0;
`endif

  // reset_n gates the request so the memory sees no request while held in reset.
  assign imem_req  = reset_n && !redirect && !jal_take && (occupancy < DEPTH_OCC);
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_ready;
  assign pop_vld   = instr_valid && decode_ready && !redirect;

  assign push_entry = '{instr: imem_rdata, pc: pend_pc, pc_plus4: pend_pc + XLEN'(4), pred: jal_take};

  assign instr_valid = !q_empty;
  assign instrD      = instr_valid ? head.instr    : '0;
  assign pcD         = instr_valid ? head.pc       : '0;
  assign pc_plus4D   = instr_valid ? head.pc_plus4 : '0;
  assign pred_taken  = instr_valid ? head.pred     : 1'b0;

  assign unused_fifo_status = ^{q_full, p_full, p_empty, p_count};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(imem_rvalid);
      if (redirect) begin
        // Everything still outstanding after this cycle is on the dead path.
        fetch_pc <= redirect_pc;
        drop     <= inflight - CW'(imem_rvalid);
      end
`ifdef FETCH_JAL_PREDICT_EN
      else if (jal_take) begin
        // Drop was zero (the JAL was pushed); all younger requests are wrong-path.
        fetch_pc <= jal_target;
        drop     <= inflight - CW'(1);
      end
`endif
      else begin
        if (issue) fetch_pc <= fetch_pc + XLEN'(4);
        if (imem_rvalid && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

  fetch_queue_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (redirect),
    .push     (push_vld),
    .push_dat (push_entry),
    .pop      (pop_vld),
    .pop_dat  (head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  // PC of every issued request, consumed in order by every response (kept or dropped).
  fetch_queue_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pend_q (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (1'b0),
    .push     (issue),
    .push_dat (fetch_pc),
    .pop      (imem_rvalid),
    .pop_dat  (pend_pc),
    .full     (p_full),
    .empty    (p_empty),
    .count    (p_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: in-order memory model with configurable latency/ready,
// directed scenarios with hand-derived expectations, one randomized latency run.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fetch_queue;

  logic        clk, reset_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, decode_ready, pred_taken;
  logic [31:0] instrD, pcD, pc_plus4D;

  int errors = 0;
  int checks = 0;

  // Memory model controls (written only by the main sequence).
  int fixed_lat  = 1;
  bit rand_lat   = 0;
  bit rand_ready = 0;
  bit jal_at8    = 0;

  // Memory model state (written only by the memory process).
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    cyc    = 0;
  int    issued = 0;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .instrD       (instrD),
    .pcD          (pcD),
    .pc_plus4D    (pc_plus4D),
    .pred_taken   (pred_taken)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a, input bit jal);
    if (jal && a == 32'h8) return 32'h0400006F;  // JAL x0, +0x40
    return {a[23:0], 8'h13};
  endfunction

  // In-order instruction memory.
  initial begin
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      imem_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (reset_n && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(mq[0].addr, jal_at8);
        void'(mq.pop_front());
      end
      @(negedge clk);
      if (!reset_n) begin
        mq.delete();
      end else if (imem_req && imem_ready) begin
        mq.push_back('{addr: imem_addr, due: cyc + (rand_lat ? int'($urandom_range(1, 5)) : fixed_lat)});
        issued++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step();
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  // Wait for the next decode handshake; ok=0 if none within budget cycles.
  task automatic next_pop(input int budget, output bit ok, output logic [31:0] pc,
                          output logic [31:0] ins, output logic [31:0] p4, output logic pred);
    ok = 0; pc = '0; ins = '0; p4 = '0; pred = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (instr_valid && decode_ready) begin
        ok = 1; pc = pcD; ins = instrD; p4 = pc_plus4D; pred = pred_taken;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0)    begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instrD !== 32'h0)     begin errors++; $display("FAIL reset_instrD got=%h exp=0", instrD); end
    checks++; if (pcD !== 32'h0)        begin errors++; $display("FAIL reset_pcD got=%h exp=0", pcD); end
    checks++; if (pc_plus4D !== 32'h0)  begin errors++; $display("FAIL reset_pc_plus4D got=%h exp=0", pc_plus4D); end
    checks++; if (pred_taken !== 1'b0)  begin errors++; $display("FAIL reset_pred got=%b exp=0", pred_taken); end
    step(); step();
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1)    begin errors++; $display("FAIL release_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0)  begin errors++; $display("FAIL release_addr got=%h exp=0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL release_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_sequential();
    bit ok; logic [31:0] pc, ins, p4, e; logic pr;
    fixed_lat = 1; decode_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      e = 32'(k * 4);
      next_pop(20, ok, pc, ins, p4, pr);
      checks++; if (!ok) begin errors++; $display("FAIL seq_timeout got=none exp=pc %h", e); break; end
      checks++; if (pc !== e)                 begin errors++; $display("FAIL seq_pc got=%h exp=%h", pc, e); end
      checks++; if (ins !== instr_of(e, 0))   begin errors++; $display("FAIL seq_instr got=%h exp=%h", ins, instr_of(e, 0)); end
      checks++; if (p4 !== e + 32'd4)         begin errors++; $display("FAIL seq_pc_plus4 got=%h exp=%h", p4, e + 32'd4); end
      checks++; if (pr !== 1'b0)              begin errors++; $display("FAIL seq_pred got=%b exp=0", pr); end
    end
  endtask

  task automatic test_stall();
    bit ok; logic [31:0] pc, ins, p4, e; logic pr; int base;
    fixed_lat = 1; decode_ready = 1'b0;
    do_reset();
    base = issued;
    repeat (10) step();
    @(negedge clk);
    checks++; if (issued - base != 4)   begin errors++; $display("FAIL stall_issued got=%0d exp=4", issued - base); end
    checks++; if (imem_req !== 1'b0)    begin errors++; $display("FAIL stall_req got=%b exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", instr_valid); end
    checks++; if (pcD !== 32'h0)        begin errors++; $display("FAIL stall_head_pc got=%h exp=0", pcD); end
    step();
    decode_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e = 32'(k * 4);
      next_pop(20, ok, pc, ins, p4, pr);
      checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got=none exp=pc %h", e); break; end
      checks++; if (pc !== e)               begin errors++; $display("FAIL stall_pc got=%h exp=%h", pc, e); end
      checks++; if (ins !== instr_of(e, 0)) begin errors++; $display("FAIL stall_instr got=%h exp=%h", ins, instr_of(e, 0)); end
    end
  endtask

  task automatic test_redirect();
    bit ok; logic [31:0] pc, ins, p4; logic pr;
    fixed_lat = 4; decode_ready = 1'b1;
    do_reset();
    step(); step(); step();           // requests 0,4,8 outstanding, none returned
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_blocked got=%b exp=0", imem_req); end
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1)      begin errors++; $display("FAIL redir_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h100)  begin errors++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
    next_pop(40, ok, pc, ins, p4, pr);
    checks++; if (!ok || pc !== 32'h100)                 begin errors++; $display("FAIL redir_first_pc got=%h exp=100", pc); end
    checks++; if (ins !== instr_of(32'h100, 0))          begin errors++; $display("FAIL redir_first_instr got=%h exp=%h", ins, instr_of(32'h100, 0)); end
    next_pop(40, ok, pc, ins, p4, pr);
    checks++; if (!ok || pc !== 32'h104)                 begin errors++; $display("FAIL redir_second_pc got=%h exp=104", pc); end
    fixed_lat = 1;
  endtask

  task automatic test_redirect_pop();
    bit ok; logic [31:0] pc, ins, p4; logic pr;
    fixed_lat = 2; decode_ready = 1'b1;
    do_reset();
    step(); step(); step();           // head=0, response for 4 arriving, 8 outstanding
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || pcD !== 32'h0) begin errors++; $display("FAIL rpop_head got=%b/%h exp=1/0", instr_valid, pcD); end
    checks++; if (imem_req !== 1'b0)                     begin errors++; $display("FAIL rpop_req_blocked got=%b exp=0", imem_req); end
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0)   begin errors++; $display("FAIL rpop_empty got=%b exp=0", instr_valid); end
    checks++; if (imem_addr !== 32'h200)  begin errors++; $display("FAIL rpop_addr got=%h exp=200", imem_addr); end
    checks++; if (imem_req !== 1'b1)      begin errors++; $display("FAIL rpop_req got=%b exp=1", imem_req); end
    next_pop(40, ok, pc, ins, p4, pr);
    checks++; if (!ok || pc !== 32'h200)  begin errors++; $display("FAIL rpop_first_pc got=%h exp=200", pc); end
    next_pop(40, ok, pc, ins, p4, pr);
    checks++; if (!ok || pc !== 32'h204)  begin errors++; $display("FAIL rpop_second_pc got=%h exp=204", pc); end
    fixed_lat = 1;
  endtask

  task automatic test_wrap();
    bit ok; logic [31:0] pc, ins, p4, e; logic pr;
    fixed_lat = 1; decode_ready = 1'b1;
    do_reset();
    step(); step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    e = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      next_pop(20, ok, pc, ins, p4, pr);
      checks++; if (!ok || pc !== e)   begin errors++; $display("FAIL wrap_pc got=%h exp=%h", pc, e); end
      checks++; if (p4 !== e + 32'd4)  begin errors++; $display("FAIL wrap_pc_plus4 got=%h exp=%h", p4, e + 32'd4); end
      e = e + 32'd4;
    end
  endtask

  task automatic test_jal();
    bit ok; logic [31:0] pc, ins, p4, exp_next; logic pr, exp_pred;
`ifdef FETCH_JAL_PREDICT_EN
    exp_next = 32'h48; exp_pred = 1'b1;
`else
    exp_next = 32'hC;  exp_pred = 1'b0;
`endif
    fixed_lat = 1; decode_ready = 1'b1; jal_at8 = 1;
    do_reset();
    next_pop(20, ok, pc, ins, p4, pr);
    next_pop(20, ok, pc, ins, p4, pr);
    next_pop(20, ok, pc, ins, p4, pr);
    checks++; if (!ok || pc !== 32'h8)     begin errors++; $display("FAIL jal_pc got=%h exp=8", pc); end
    checks++; if (ins !== 32'h0400006F)    begin errors++; $display("FAIL jal_instr got=%h exp=0400006f", ins); end
    checks++; if (pr !== exp_pred)         begin errors++; $display("FAIL jal_pred got=%b exp=%b", pr, exp_pred); end
    next_pop(20, ok, pc, ins, p4, pr);
    checks++; if (!ok || pc !== exp_next)  begin errors++; $display("FAIL jal_next_pc got=%h exp=%h", pc, exp_next); end
    checks++; if (pr !== 1'b0)             begin errors++; $display("FAIL jal_next_pred got=%b exp=0", pr); end
    jal_at8 = 0;
  endtask

  task automatic test_random();
    logic [31:0] e; int pops;
    rand_lat = 1; rand_ready = 1; decode_ready = 1'b1;
    do_reset();
    e = 32'h0; pops = 0;
    for (int c = 0; c < 8000 && pops < 300; c++) begin
      step();
      decode_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++; if (mq.size() + int'(imem_rvalid) > 4) begin errors++; $display("FAIL rand_inflight got=%0d exp<=4", mq.size() + int'(imem_rvalid)); end
      if (instr_valid && decode_ready) begin
        checks++; if (pcD !== e)               begin errors++; $display("FAIL rand_pc got=%h exp=%h", pcD, e); end
        checks++; if (instrD !== instr_of(e, 0)) begin errors++; $display("FAIL rand_instr got=%h exp=%h", instrD, instr_of(e, 0)); end
        e = e + 32'd4;
        pops++;
      end
    end
    checks++; if (pops != 300) begin errors++; $display("FAIL rand_count got=%0d exp=300", pops); end
    rand_lat = 0; rand_ready = 0; decode_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    bit ok; logic [31:0] pc, ins, p4; logic pr;
    fixed_lat = 1; decode_ready = 1'b1;
    do_reset();
    repeat (5) step();
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got=%b exp=1", instr_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b0)    begin errors++; $display("FAIL areset_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0)  begin errors++; $display("FAIL areset_addr got=%h exp=0", imem_addr); end
    checks++; if (pcD !== 32'h0)        begin errors++; $display("FAIL areset_pcD got=%h exp=0", pcD); end
    step(); step();
    reset_n = 1'b1;
    next_pop(20, ok, pc, ins, p4, pr);
    checks++; if (!ok || pc !== 32'h0)  begin errors++; $display("FAIL areset_first_pc got=%h exp=0", pc); end
  endtask

  initial begin
    reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; decode_ready = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_jal();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
